spi_boot_slave: RTL and testbench
=================================

// Module: spi_boot_slave
// PURPOSE
//  SPI mode-0 responder (CPOL=0, CPHA=0) inside TOP. Receives boot traffic from an external SPI
//  master and writes/reads the instruction memory (IMEM) while PROG is asserted.
//  Bytes are MSbit-first; 32-bit words are sent LS byte first.
//  Oversampled design: SCLK/CSn/MOSI are synchronized into i_clk, with no SCLK-clocked logic.
// PARAMETERS
//  ADDR_W    9              IMEM word-address width (depth 2**ADDR_W)
//  CMD_WR    8'h02          command byte: sequential IMEM write from word 0
//  CMD_RD    8'h01          command byte: IMEM read, address per word
//  END_WORD  32'hFFFFFFFF   write-stream terminator (never written to IMEM)
// PORTS
//  i_clk        in   1       system clock; SCLK <= i_clk/16 required
//  i_rstn       in   1       asynchronous reset, active low
//  i_prog       in   1       1 = boot/programming mode; 0 = all SPI traffic ignored
//  i_CSn        in   1       SPI chip select, active low (async, synchronized inside)
//  i_SCLK       in   1       SPI clock (async)
//  i_MOSI       in   1       SPI data in (async)
//  o_MISO       out  1       SPI data out
//  o_mem_we     out  1       IMEM write strobe, 1 cycle
//  o_mem_re     out  1       IMEM read strobe, 1 cycle; i_mem_rdata valid on the next cycle
//  o_mem_addr   out  ADDR_W  IMEM word address
//  o_mem_wdata  out  32      IMEM write data
//  i_mem_rdata  in   32      IMEM read data, 1-cycle latency after o_mem_re
//  o_boot_done  out  1       sticky: END_WORD received; cleared only by reset
//  o_overflow   out  1       sticky: write attempted beyond depth (data dropped)
// BEHAVIOUR
//  Reset: all outputs 0, MISO=0, FSM=IDLE, write pointer=0, shift registers cleared.
//  Sync: 2-FF on CSn/SCLK/MOSI. Rising SCLK edge samples MOSI; falling edge shifts MISO.
//  Edges are detected on synchronized SCLK; edges count only while CSn is low.
//  Byte counter 0..7; a byte completes on the 8th rising edge. Word = 4 bytes, assembled as
//  {b3,b2,b1,b0}, where b0 is received first.
//  FSM:
//   IDLE: CSn falling with i_prog=1 -> CMD. tx reg=8'h00.
//   CMD: 1st byte == CMD_WR -> WRITE (ptr=0); == CMD_RD -> READ; other -> IGNORE.
//   WRITE: on word complete:
//    - == END_WORD -> boot_done=1, go to DONE.
//    - else we=1 one cycle after the completing edge, addr=ptr, ptr++.
//    - If ptr == 2**ADDR_W, drop the write and set o_overflow.
//   READ: on word complete, re=1 next cycle with addr = word[ADDR_W+1:2] (byte address in,
//    low 2 bits ignored). rdata is captured into the 32-bit tx reg the cycle after.
//   DONE/IGNORE: receive and discard; MISO=0.
//   Any state: CSn rise -> IDLE. Partial byte/word discarded, no mem strobe, ptr kept.
//   i_prog=0 forces IDLE.
//  MISO:
//   - Bit 7 of the current tx byte is driven from CSn-fall or tx load.
//   - Each falling edge advances one bit.
//   - WRITE returns the previous word (echo, one-word lag; first word returns 0).
//   - READ returns the data for the previous address, LS byte first (one-word lag).
//   - Tx load completes within 4 i_clk after the last rising edge of a word.
//  Simultaneous CSn rise and word completion: CSn wins, no strobe.
//  o_mem_we and o_mem_re are never high together. Address wrap never occurs (overflow instead).
// STRUCTURE
//  spi_boot_defines.vh: CMD_WR, CMD_RD, END_WORD, FSM state encodings (IDLE,CMD,WRITE,READ,DONE,IGNORE).
//  Sub-module spi_slave_phy:
//   - synchronizers, SCLK edge detect, rx/tx 8-bit shift registers;
//   - outputs byte_valid/rx_byte; accepts tx_load/tx_byte.
//  spi_boot_slave holds the FSM, word assembly, pointer and IMEM interface.
// TESTING
//  1 Write 02, then 00000013, 00100093, FFFFFFFF
//    -> we at addr 0,1 with those data; boot_done=1; MISO echo bytes 00.., 13 00 00 00.
//  2 Read 01, addresses 0,4,8 -> re at 0,1,2; MISO of words 2,3 = 13 00 00 00, 93 00 10 00.
//  3 CSn rise after 5 bits of byte 3 of a write word -> no we; next session writes at same ptr.
//  4 Command 8'h55, then 2 words -> no we/re, MISO all 0; next 02 session accepted.
//  5 i_prog=0, command 02 + word -> no strobes; i_rstn low mid-word -> outputs 0 in same cycle.
//  6 Write 513 words with ADDR_W=9 -> last write dropped, o_overflow=1, no wrap to addr 0.

Source files
------------

// File: rtl/spi_boot_slave_pkg.sv
// Shared command codes, stream terminator and FSM encoding for the SPI boot slave.
package spi_boot_slave_pkg;

    localparam logic [7:0]  CMD_WR   = 8'h02;
    localparam logic [7:0]  CMD_RD   = 8'h01;
    localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
        ST_DONE   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/spi_boot_slave_phy.sv
// SPI mode-0 bit layer: input synchronizers, SCLK edge detect, rx/tx byte shifters.
module spi_boot_slave_phy (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_csn,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_tx_load,
    input  logic [7:0] i_tx_byte,
    output logic       o_miso,
    output logic       o_cs_fall,
    output logic       o_cs_rise,
    output logic       o_byte_valid,
    output logic [7:0] o_rx_byte
);

    logic [1:0] r_csn_s, r_sclk_s, r_mosi_s;
    logic       r_csn_d, r_sclk_d;
    logic [2:0] r_rx_cnt, r_fall_cnt;
    logic [7:0] r_rx_sh, r_tx_sh;
    logic       r_byte_valid;
    logic       w_cs_act, w_rise, w_fall;

    assign w_cs_act     = ~r_csn_s[1];
    assign w_rise       = r_sclk_s[1] & ~r_sclk_d & w_cs_act;
    assign w_fall       = ~r_sclk_s[1] & r_sclk_d & w_cs_act;
    assign o_cs_fall    = ~r_csn_s[1] & r_csn_d;
    assign o_cs_rise    = r_csn_s[1] & ~r_csn_d;
    assign o_miso       = r_tx_sh[7];
    assign o_byte_valid = r_byte_valid;
    assign o_rx_byte    = r_rx_sh;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_csn_s      <= 2'b11;
            r_sclk_s     <= 2'b00;
            r_mosi_s     <= 2'b00;
            r_csn_d      <= 1'b1;
            r_sclk_d     <= 1'b0;
            r_rx_cnt     <= '0;
            r_fall_cnt   <= '0;
            r_rx_sh      <= '0;
            r_tx_sh      <= '0;
            r_byte_valid <= 1'b0;
        end else begin
            r_csn_s      <= {r_csn_s[0], i_csn};
            r_sclk_s     <= {r_sclk_s[0], i_sclk};
            r_mosi_s     <= {r_mosi_s[0], i_mosi};
            r_csn_d      <= r_csn_s[1];
            r_sclk_d     <= r_sclk_s[1];
            r_byte_valid <= 1'b0;
            if (!w_cs_act) begin
                r_rx_cnt   <= '0;
                r_fall_cnt <= '0;
                r_rx_sh    <= '0;
                r_tx_sh    <= '0;
            end else begin
                if (w_rise) begin
                    r_rx_sh  <= {r_rx_sh[6:0], r_mosi_s[1]};
                    r_rx_cnt <= r_rx_cnt + 3'd1;
                    if (r_rx_cnt == 3'd7) r_byte_valid <= 1'b1;
                end
                if (w_fall) r_fall_cnt <= r_fall_cnt + 3'd1;
                // The next byte is loaded right after the 8th rise, so the 8th fall must not shift it.
                if (i_tx_load)
                    r_tx_sh <= i_tx_byte;
                else if (w_fall && r_fall_cnt != 3'd7)
                    r_tx_sh <= {r_tx_sh[6:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/spi_boot_slave.sv
// SPI boot slave: command decode FSM, 32-bit word assembly, IMEM write pointer and read path.
module spi_boot_slave
    import spi_boot_slave_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_prog,
    input  logic              i_CSn,
    input  logic              i_SCLK,
    input  logic              i_MOSI,
    output logic              o_MISO,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_boot_done,
    output logic              o_overflow
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t        r_state, w_next;
    logic          w_cs_fall, w_cs_rise, w_byte_valid, w_miso, w_last;
    logic [7:0]    w_rx_byte;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_word_lo;
    logic [31:0]   w_word, r_tx_word;
    logic [ADDR_W:0] r_ptr;
    logic          r_rd_pend;
    logic          w_we_nxt, w_re_nxt, w_ovf_nxt, w_done_nxt, w_tx_load, w_txw_ld;
    logic [7:0]    w_tx_byte;
    logic [31:0]   w_txw_nxt;

    spi_boot_slave_phy u_phy (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_csn        (i_CSn),
        .i_sclk       (i_SCLK),
        .i_mosi       (i_MOSI),
        .i_tx_load    (w_tx_load),
        .i_tx_byte    (w_tx_byte),
        .o_miso       (w_miso),
        .o_cs_fall    (w_cs_fall),
        .o_cs_rise    (w_cs_rise),
        .o_byte_valid (w_byte_valid),
        .o_rx_byte    (w_rx_byte)
    );

    assign w_word = {w_rx_byte, r_word_lo};
    assign w_last = w_byte_valid & (r_byte_idx == 2'd3) & ~w_cs_rise;
    assign o_MISO = w_miso & (r_state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!i_prog || w_cs_rise) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_cs_fall) w_next = ST_CMD;
                ST_CMD:   if (w_byte_valid)
                              w_next = (w_rx_byte == CMD_WR) ? ST_WRITE :
                                       (w_rx_byte == CMD_RD) ? ST_READ  : ST_IGNORE;
                ST_WRITE: if (w_last && w_word == END_WORD) w_next = ST_DONE;
                default:  w_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_we_nxt   = 1'b0;
        w_re_nxt   = 1'b0;
        w_ovf_nxt  = 1'b0;
        w_done_nxt = 1'b0;
        w_tx_load  = 1'b0;
        w_tx_byte  = 8'h00;
        w_txw_ld   = 1'b0;
        w_txw_nxt  = '0;
        if (i_prog && !w_cs_rise) begin
            case (r_state)
                ST_IDLE: if (w_cs_fall) begin
                    w_tx_load = 1'b1;
                    w_txw_ld  = 1'b1;
                end
                ST_CMD: if (w_byte_valid) begin
                    w_tx_load = 1'b1;
                    w_txw_ld  = 1'b1;
                end
                ST_WRITE: begin
                    if (w_last) begin
                        w_tx_load = 1'b1;
                        w_txw_ld  = 1'b1;
                        if (w_word == END_WORD) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_tx_byte = w_word[7:0];
                            w_txw_nxt = w_word;
                            if (r_ptr == DEPTH) w_ovf_nxt = 1'b1;
                            else                w_we_nxt  = 1'b1;
                        end
                    end else if (w_byte_valid) begin
                        w_tx_load = 1'b1;
                        w_tx_byte = sel_byte(r_tx_word, r_byte_idx + 2'd1);
                    end
                end
                ST_READ: begin
                    // Read data arrives one cycle after the strobe and becomes the next tx word.
                    if (r_rd_pend) begin
                        w_tx_load = 1'b1;
                        w_tx_byte = i_mem_rdata[7:0];
                        w_txw_ld  = 1'b1;
                        w_txw_nxt = i_mem_rdata;
                    end else if (w_last) begin
                        w_re_nxt = 1'b1;
                    end else if (w_byte_valid) begin
                        w_tx_load = 1'b1;
                        w_tx_byte = sel_byte(r_tx_word, r_byte_idx + 2'd1);
                    end
                end
                default: if (w_byte_valid) w_tx_load = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_mem_we    <= 1'b0;
            o_mem_re    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_boot_done <= 1'b0;
            o_overflow  <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_ptr       <= '0;
            r_tx_word   <= '0;
            r_byte_idx  <= '0;
            r_word_lo   <= '0;
        end else begin
            o_mem_we  <= w_we_nxt;
            o_mem_re  <= w_re_nxt;
            r_rd_pend <= o_mem_re;
            if (w_we_nxt) begin
                o_mem_addr  <= r_ptr[ADDR_W-1:0];
                o_mem_wdata <= w_word;
                r_ptr       <= r_ptr + 1'b1;
            end
            if (w_re_nxt)   o_mem_addr  <= w_word[ADDR_W+1:2];
            if (w_ovf_nxt)  o_overflow  <= 1'b1;
            if (w_done_nxt) o_boot_done <= 1'b1;
            if (w_txw_ld)   r_tx_word   <= w_txw_nxt;
            if (r_state == ST_CMD && w_next == ST_WRITE) r_ptr <= '0;
            if (r_state inside {ST_WRITE, ST_READ, ST_DONE, ST_IGNORE} && w_byte_valid && !w_cs_rise) begin
                r_byte_idx <= r_byte_idx + 2'd1;
                r_word_lo  <= {w_rx_byte, r_word_lo[23:8]};
            end else if (r_state == ST_IDLE || r_state == ST_CMD) begin
                r_byte_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_boot_slave.sv
// Directed bench for spi_boot_slave: write/echo, read-back, aborts, ignore, prog gating, reset, overflow.
module tb_spi_boot_slave;

    localparam int AW   = 4;
    localparam int HALF = 80;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic          prog = 1'b1;
    logic          csn  = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso, we, re, done, ovf;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata = '0;
    logic [31:0]   mem [16] = '{default: '0};

    int n_checks = 0;
    int n_err    = 0;
    int we_cnt   = 0;
    int re_cnt   = 0;
    int both_cnt = 0;
    logic [AW-1:0] we_addr [64];
    logic [AW-1:0] re_addr [64];
    logic [31:0]   we_data [64];

    spi_boot_slave #(.ADDR_W(AW)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_prog      (prog),
        .i_CSn       (csn),
        .i_SCLK      (sclk),
        .i_MOSI      (mosi),
        .o_MISO      (miso),
        .o_mem_we    (we),
        .o_mem_re    (re),
        .o_mem_addr  (addr),
        .o_mem_wdata (wdata),
        .i_mem_rdata (rdata),
        .o_boot_done (done),
        .o_overflow  (ovf)
    );

    always #5 clk = ~clk;

    // IMEM model and strobe log, sampled on the falling clock edge
    always @(negedge clk) begin
        if (we && re) both_cnt <= both_cnt + 1;
        if (we) begin
            mem[addr]       <= wdata;
            we_addr[we_cnt] <= addr;
            we_data[we_cnt] <= wdata;
            we_cnt          <= we_cnt + 1;
        end
        if (re) begin
            rdata           <= mem[addr];
            re_addr[re_cnt] <= addr;
            re_cnt          <= re_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #(HALF);
            r[i] = miso;
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_word(input logic [31:0] w, output logic [31:0] r);
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            spi_bits(w[k*8 +: 8], 8, b);
            r[k*8 +: 8] = b;
        end
    endtask

    task automatic cs_start();
        csn = 1'b0;
        #(2*HALF);
    endtask

    task automatic cs_end();
        #(HALF);
        csn = 1'b1;
        #200;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] r;
        int          base;

        #22;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_flags", {28'd0, we, re, done, ovf}, 32'd0);
        chk("rst_addr", {28'd0, addr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        rstn = 1'b1;
        #100;

        // 1: write two words then terminator, MISO echoes with one-word lag
        cs_start();
        spi_bits(8'h02, 8, b);           chk("wr_cmd_miso", {24'd0, b}, 32'd0);
        spi_word(32'h0000_0013, r);      chk("wr_w0_miso", r, 32'd0);
        spi_word(32'h0010_0093, r);      chk("wr_w1_echo", r, 32'h0000_0013);
        spi_word(32'hFFFF_FFFF, r);      chk("wr_end_echo", r, 32'h0010_0093);
        cs_end();
        chk("wr_we_cnt", we_cnt, 32'd2);
        chk("wr_addr01", {24'd0, we_addr[0], we_addr[1]}, 32'h01);
        chk("wr_data0", we_data[0], 32'h0000_0013);
        chk("wr_data1", we_data[1], 32'h0010_0093);
        chk("wr_boot_done", {31'd0, done}, 32'd1);

        // 2: read byte addresses 0,4,8
        cs_start();
        spi_bits(8'h01, 8, b);
        spi_word(32'd0, r);              chk("rd_w0_miso", r, 32'd0);
        spi_word(32'd4, r);              chk("rd_w1_miso", r, 32'h0000_0013);
        spi_word(32'd8, r);              chk("rd_w2_miso", r, 32'h0010_0093);
        cs_end();
        chk("rd_re_cnt", re_cnt, 32'd3);
        chk("rd_addrs", {20'd0, re_addr[0], re_addr[1], re_addr[2]}, 32'h012);
        chk("rd_no_we", we_cnt, 32'd2);

        // 3: abort 5 bits into byte 3 of the second word
        cs_start();
        spi_bits(8'h02, 8, b);
        spi_word(32'h1111_1111, r);
        spi_bits(8'hAA, 8, b);
        spi_bits(8'hBB, 8, b);
        spi_bits(8'hCC, 8, b);
        spi_bits(8'hDD, 5, b);
        cs_end();
        chk("abort_we_cnt", we_cnt, 32'd3);
        cs_start();
        spi_bits(8'h02, 8, b);
        spi_word(32'h2222_2222, r);      chk("abort_next_miso", r, 32'd0);
        cs_end();
        chk("abort_next_cnt", we_cnt, 32'd4);
        chk("abort_next_wr", {we_data[3][27:0], we_addr[3]}, {28'h222_2222, 4'h0});

        // 4: unknown command ignored
        cs_start();
        spi_bits(8'h55, 8, b);           chk("ign_cmd_miso", {24'd0, b}, 32'd0);
        spi_word(32'h1234_5678, r);      chk("ign_w0_miso", r, 32'd0);
        spi_word(32'h9ABC_DEF0, r);      chk("ign_w1_miso", r, 32'd0);
        cs_end();
        chk("ign_strobes", we_cnt + re_cnt, 32'd7);
        cs_start();
        spi_bits(8'h02, 8, b);
        spi_word(32'h3333_3333, r);
        cs_end();
        chk("ign_next_cnt", we_cnt, 32'd5);
        chk("ign_next_data", we_data[4], 32'h3333_3333);

        // 5: prog low ignores traffic; async reset mid-word
        prog = 1'b0;
        cs_start();
        spi_bits(8'h02, 8, b);
        spi_word(32'h4444_4444, r);
        cs_end();
        prog = 1'b1;
        chk("noprog_strobes", we_cnt + re_cnt, 32'd8);
        cs_start();
        spi_bits(8'h02, 8, b);
        spi_bits(8'h55, 8, b);
        spi_bits(8'h66, 8, b);
        chk("pre_rst_state", {done, wdata[30:0]}, {1'b1, 31'h3333_3333});
        #4;
        rstn = 1'b0;
        #1;
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_wdata", wdata, 32'd0);
        chk("midrst_misc", {28'd0, we, re, ovf, miso}, 32'd0);
        #5;
        csn = 1'b1;
        #100;
        rstn = 1'b1;
        #100;

        // 6: overflow after 2**AW words
        chk("ovf_pre", {31'd0, ovf}, 32'd0);
        base = we_cnt;
        cs_start();
        spi_bits(8'h02, 8, b);
        for (int k = 0; k < 17; k++) spi_word(32'h100 + k, r);
        cs_end();
        chk("ovf_last_echo", r, 32'h10F);
        chk("ovf_we_cnt", we_cnt - base, 32'd16);
        chk("ovf_first_addr", {28'd0, we_addr[base]}, 32'd0);
        chk("ovf_last_addr", {28'd0, we_addr[base+15]}, 32'd15);
        chk("ovf_last_data", we_data[base+15], 32'h10F);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        chk("we_re_overlap", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
